// File: rtl/canvas_pkg.sv
// Shared canvas geometry, scheduler FSM states and the write bundle type.
// Also used by the VGA controller and the pattern generator.
package canvas_pkg;

    localparam int COLS    = 40;
    localparam int ROWS    = 30;
    localparam int COLOR_W = 6;
    localparam int X_W     = 6;
    localparam int Y_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } cell_write_t;

endpackage

// File: rtl/canvas_clear_sweeper.sv
// Raster sweep over every canvas cell, x inner and y outer.
// Emits one write per cycle while busy, then a one-cycle done pulse.
module canvas_clear_sweeper
    import canvas_pkg::*;
#(
    parameter int COLS = canvas_pkg::COLS,
    parameter int ROWS = canvas_pkg::ROWS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [COLOR_W-1:0] color_i,
    output cell_write_t        cell_o,
    output logic               busy_o,
    output logic               last_o,
    output logic               done_o
);

    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [COLOR_W-1:0] color_q;
    logic               busy_q;
    logic               done_q;
    logic               x_end;
    logic               y_end;

    // Wrap points are compared explicitly; counters never rely on overflow.
    assign x_end  = (x_q == X_W'(COLS - 1));
    assign y_end  = (y_q == Y_W'(ROWS - 1));
    assign last_o = busy_q && x_end && y_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start_i) begin
                    busy_q  <= 1'b1;
                    x_q     <= '0;
                    y_q     <= '0;
                    color_q <= color_i;
                end
            end else if (x_end) begin
                x_q <= '0;
                if (y_end) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    y_q    <= '0;
                end else begin
                    y_q <= y_q + Y_W'(1);
                end
            end else begin
                x_q <= x_q + X_W'(1);
            end
        end
    end

    assign cell_o = '{x: x_q, y: y_q, color: color_q};
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/canvas_write_scheduler.sv
// Owns the canvas write port: full-canvas clear sweep plus a
// paint/pattern arbiter with a starvation guard for the pattern side.
module canvas_write_scheduler
    import canvas_pkg::*;
#(
    parameter int COLS         = canvas_pkg::COLS,
    parameter int ROWS         = canvas_pkg::ROWS,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    input  logic               paint_req,
    input  logic [X_W-1:0]     paint_x,
    input  logic [Y_W-1:0]     paint_y,
    input  logic [COLOR_W-1:0] paint_color,
    output logic               paint_ack,
    input  logic               pat_req,
    input  logic [X_W-1:0]     pat_x,
    input  logic [Y_W-1:0]     pat_y,
    input  logic [COLOR_W-1:0] pat_color,
    output logic               pat_ack,
    output logic               wr_en,
    output logic [X_W-1:0]     wr_x,
    output logic [Y_W-1:0]     wr_y,
    output logic [COLOR_W-1:0] wr_color,
    output logic               clear_busy,
    output logic               clear_done,
    output logic               range_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_e        state_q;
    logic [SW-1:0] starve_q;
    logic          paint_ack_q;
    logic          pat_ack_q;
    logic          arb_wr_q;
    logic          range_err_q;
    cell_write_t   arb_cell_q;

    cell_write_t   sweep_cell;
    cell_write_t   sel_cell;
    logic          sweep_busy;
    logic          sweep_last;
    logic          sweep_done;
    logic          sweep_start;
    logic          arb_open;
    logic          paint_ok;
    logic          pat_ok;
    logic          gnt_paint;
    logic          gnt_pat;
    logic          gnt_any;
    logic          sel_legal;

    always_comb begin
        sweep_start = (state_q == ST_IDLE) && clear_req;
        // DONE issues no write, so the port is free for a grant there.
        arb_open  = ((state_q == ST_IDLE) && !clear_req)
                  || (state_q == ST_DONE);
        paint_ok  = paint_req && !paint_ack_q;
        pat_ok    = pat_req && !pat_ack_q;
        gnt_pat   = arb_open && pat_ok
                  && (!paint_ok || starve_q == SW'(STARVE_LIMIT));
        gnt_paint = arb_open && paint_ok && !gnt_pat;
        gnt_any   = gnt_pat || gnt_paint;
        sel_cell  = gnt_pat ? '{x: pat_x, y: pat_y, color: pat_color}
                            : '{x: paint_x, y: paint_y, color: paint_color};
        sel_legal = (sel_cell.x < X_W'(COLS)) && (sel_cell.y < Y_W'(ROWS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            paint_ack_q <= 1'b0;
            pat_ack_q   <= 1'b0;
            arb_wr_q    <= 1'b0;
            range_err_q <= 1'b0;
            arb_cell_q  <= '0;
        end else begin
            paint_ack_q <= gnt_paint;
            pat_ack_q   <= gnt_pat;
            arb_wr_q    <= gnt_any && sel_legal;
            range_err_q <= gnt_any && !sel_legal;
            arb_cell_q  <= (gnt_any && sel_legal) ? sel_cell : '0;

            if (gnt_pat) begin
                starve_q <= '0;
            end else if (gnt_paint && pat_req
                         && starve_q != SW'(STARVE_LIMIT)) begin
                starve_q <= starve_q + SW'(1);
            end

            unique case (state_q)
                ST_IDLE:  if (clear_req) state_q <= ST_CLEAR;
                ST_CLEAR: if (sweep_last) state_q <= ST_DONE;
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    canvas_clear_sweeper #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_sweeper (
        .clk     (clk),
        .rst     (rst),
        .start_i (sweep_start),
        .color_i (clear_color),
        .cell_o  (sweep_cell),
        .busy_o  (sweep_busy),
        .last_o  (sweep_last),
        .done_o  (sweep_done)
    );

    // Sweep and arbiter writes never overlap, so this is a pure register select.
    assign wr_en      = sweep_busy | arb_wr_q;
    assign wr_x       = sweep_busy ? sweep_cell.x : arb_cell_q.x;
    assign wr_y       = sweep_busy ? sweep_cell.y : arb_cell_q.y;
    assign wr_color   = sweep_busy ? sweep_cell.color : arb_cell_q.color;
    assign paint_ack  = paint_ack_q;
    assign pat_ack    = pat_ack_q;
    assign clear_busy = sweep_busy;
    assign clear_done = sweep_done;
    assign range_err  = range_err_q;

endmodule

// File: tb/tb_canvas_write_scheduler.sv
// Bench for canvas_write_scheduler: directed scenarios plus random
// requesters compared against a cell-index reference model.
module tb_canvas_write_scheduler;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int LIMIT = 4;
    localparam int NCELL = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_req;
    logic [5:0] clear_color;
    logic       paint_req;
    logic [5:0] paint_x;
    logic [4:0] paint_y;
    logic [5:0] paint_color;
    logic       paint_ack;
    logic       pat_req;
    logic [5:0] pat_x;
    logic [4:0] pat_y;
    logic [5:0] pat_color;
    logic       pat_ack;
    logic       wr_en;
    logic [5:0] wr_x;
    logic [4:0] wr_y;
    logic [5:0] wr_color;
    logic       clear_busy;
    logic       clear_done;
    logic       range_err;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    canvas_write_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .paint_req   (paint_req),
        .paint_x     (paint_x),
        .paint_y     (paint_y),
        .paint_color (paint_color),
        .paint_ack   (paint_ack),
        .pat_req     (pat_req),
        .pat_x       (pat_x),
        .pat_y       (pat_y),
        .pat_color   (pat_color),
        .pat_ack     (pat_ack),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .range_err   (range_err)
    );

    // Reference model: mode 0 idle, 1 sweeping cell index m_k, 2 done.
    int         m_mode;
    int         m_k;
    int         m_starve;
    logic [5:0] m_col;
    logic       e_wr, e_pa, e_ta, e_busy, e_done, e_err;
    logic [5:0] e_x, e_c;
    logic [4:0] e_y;

    wire [22:0] act_v = {wr_en, wr_x, wr_y, wr_color, paint_ack,
                         pat_ack, clear_busy, clear_done, range_err};
    wire [22:0] exp_v = {e_wr, e_x, e_y, e_c, e_pa,
                         e_ta, e_busy, e_done, e_err};

    always @(posedge clk) begin : ref_model
        logic       pe, te, tp;
        logic [5:0] gx, gc;
        logic [4:0] gy;
        if (rst) begin
            m_mode   <= 0;
            m_k      <= 0;
            m_starve <= 0;
            m_col    <= '0;
            {e_wr, e_x, e_y, e_c, e_pa, e_ta, e_busy, e_done, e_err} <= '0;
        end else begin
            {e_wr, e_x, e_y, e_c, e_pa, e_ta, e_busy, e_done, e_err} <= '0;
            if (m_mode == 1) begin
                if (m_k == NCELL - 1) begin
                    m_mode <= 2;
                    e_done <= 1'b1;
                end else begin
                    m_k    <= m_k + 1;
                    e_wr   <= 1'b1;
                    e_busy <= 1'b1;
                    e_x    <= 6'((m_k + 1) % COLS);
                    e_y    <= 5'((m_k + 1) / COLS);
                    e_c    <= m_col;
                end
            end else if (m_mode == 0 && clear_req) begin
                m_mode <= 1;
                m_k    <= 0;
                m_col  <= clear_color;
                e_wr   <= 1'b1;
                e_busy <= 1'b1;
                e_c    <= clear_color;
            end else begin
                m_mode <= 0;
                pe = paint_req && !e_pa;
                te = pat_req && !e_ta;
                tp = te && (!pe || m_starve == LIMIT);
                if (tp || pe) begin
                    gx = tp ? pat_x : paint_x;
                    gy = tp ? pat_y : paint_y;
                    gc = tp ? pat_color : paint_color;
                    if (tp) begin
                        e_ta     <= 1'b1;
                        m_starve <= 0;
                    end else begin
                        e_pa <= 1'b1;
                        if (pat_req && m_starve < LIMIT)
                            m_starve <= m_starve + 1;
                    end
                    if (int'(gx) < COLS && int'(gy) < ROWS) begin
                        e_wr <= 1'b1;
                        e_x  <= gx;
                        e_y  <= gy;
                        e_c  <= gc;
                    end else begin
                        e_err <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        nvec++;
        if (act_v !== 23'd0) begin
            nerr++;
            $display("FAIL reset_hold: got %h want %h", act_v, 23'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (act_v !== 23'd0) begin
            nerr++;
            $display("FAIL reset_idle: got %h want %h", act_v, 23'd0);
        end
    endtask

    task automatic test_single_paint();
        @(negedge clk);
        paint_req = 1'b1; paint_x = 6'd3; paint_y = 5'd7;
        paint_color = 6'b001100;
        @(negedge clk);
        nvec++;
        if ({wr_en, wr_x, wr_y, wr_color, paint_ack, range_err} !==
            {1'b1, 6'd3, 5'd7, 6'b001100, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL paint_first: got %b %0d %0d %h ack=%b err=%b",
                     wr_en, wr_x, wr_y, wr_color, paint_ack, range_err);
        end
        @(negedge clk);
        nvec++;
        if ({wr_en, paint_ack} !== 2'b00) begin
            nerr++;
            $display("FAIL paint_gap: got wr=%b ack=%b want 0 0",
                     wr_en, paint_ack);
        end
        @(negedge clk);
        nvec++;
        if ({wr_en, paint_ack, wr_x, wr_y} !==
            {1'b1, 1'b1, 6'd3, 5'd7}) begin
            nerr++;
            $display("FAIL paint_second: got wr=%b ack=%b %0d,%0d",
                     wr_en, paint_ack, wr_x, wr_y);
        end
        paint_req = 1'b0;
        @(negedge clk);
        nvec++;
        if (act_v !== exp_v) begin
            nerr++;
            $display("FAIL paint_release: got %h want %h", act_v, exp_v);
        end
    endtask

    task automatic test_range();
        logic [5:0] tx [5] = '{6'd40, 6'd39, 6'd0,  6'd63, 6'd39};
        logic [4:0] ty [5] = '{5'd5,  5'd29, 5'd30, 5'd31, 5'd0};
        bit         bad[5] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
        for (int i = 0; i < 5; i++) begin
            paint_req = 1'b1; paint_x = tx[i]; paint_y = ty[i];
            paint_color = 6'h21;
            @(negedge clk);
            nvec++;
            if ({paint_ack, range_err, wr_en} !== {1'b1, bad[i], !bad[i]}
                || act_v !== exp_v) begin
                nerr++;
                $display("FAIL range_%0d: ack=%b err=%b wr=%b want 1 %b %b",
                         i, paint_ack, range_err, wr_en, bad[i], !bad[i]);
            end
            paint_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int run = 0, maxrun = 0, npat = 0, nwr = 0;
        paint_req = 1'b1; paint_x = 6'd1; paint_y = 5'd2;
        paint_color = 6'h11;
        pat_req = 1'b1; pat_x = 6'd3; pat_y = 5'd4; pat_color = 6'h22;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            nvec++;
            if (act_v !== exp_v) begin
                nerr++;
                $display("FAIL b2b c=%0d: got %h want %h", c, act_v, exp_v);
            end
            if (paint_ack) run++;
            if (pat_ack) begin npat++; run = 0; end
            if (run > maxrun) maxrun = run;
            if (wr_en) nwr++;
        end
        paint_req = 1'b0;
        pat_req = 1'b0;
        nvec++;
        if (maxrun > LIMIT || npat != 20 || nwr != 40) begin
            nerr++;
            $display("FAIL b2b_share: run=%0d pat=%0d wr=%0d want <=%0d 20 40",
                     maxrun, npat, nwr, LIMIT);
        end
        @(negedge clk);
    endtask

    task automatic test_clear(input bit with_paint);
        int    n = 0, nb = 0, last_wr = -1, done_at = -1;
        string nm = with_paint ? "clear_vs_paint" : "clear";
        clear_req = 1'b1; clear_color = 6'h3F;
        if (with_paint) begin
            paint_req = 1'b1; paint_x = 6'd5; paint_y = 5'd6;
            paint_color = 6'h2A;
        end
        for (int c = 0; c < 1300 && done_at < 0; c++) begin
            @(negedge clk);
            clear_req = 1'b0;
            nvec++;
            if (act_v !== exp_v) begin
                nerr++;
                $display("FAIL %s c=%0d: got %h want %h", nm, c, act_v, exp_v);
            end
            if (wr_en) begin
                n++;
                last_wr = c;
                if (n == 1 || n == 40 || n == 41 || n == NCELL) begin
                    nvec++;
                    if ({wr_x, wr_y, wr_color} !==
                        {6'((n - 1) % COLS), 5'((n - 1) / COLS), 6'h3F}) begin
                        nerr++;
                        $display("FAIL %s_cell%0d: got %0d,%0d %h", nm, n,
                                 wr_x, wr_y, wr_color);
                    end
                end
                if (!with_paint && n == 600) clear_req = 1'b1;
            end
            if (clear_busy) nb++;
            if (with_paint && paint_ack) begin
                nvec++;
                nerr++;
                $display("FAIL %s_early_ack: got ack at c=%0d want none",
                         nm, c);
            end
            if (clear_done) done_at = c;
        end
        nvec++;
        if (done_at < 0 || n != NCELL || nb != NCELL
            || last_wr != done_at - 1) begin
            nerr++;
            $display("FAIL %s_count: wr=%0d busy=%0d last=%0d done=%0d",
                     nm, n, nb, last_wr, done_at);
        end
        if (with_paint) begin
            @(negedge clk);
            nvec++;
            if ({paint_ack, wr_en, wr_x, wr_y, wr_color} !==
                {1'b1, 1'b1, 6'd5, 5'd6, 6'h2A}) begin
                nerr++;
                $display("FAIL %s_late_ack: ack=%b wr=%b %0d,%0d %h",
                         nm, paint_ack, wr_en, wr_x, wr_y, wr_color);
            end
            paint_req = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        int n = 0;
        bit seen = 1'b0;
        clear_req = 1'b1; clear_color = 6'h15;
        for (int c = 0; c < 1300 && n < 500; c++) begin
            @(negedge clk);
            clear_req = 1'b0;
            if (wr_en) n++;
        end
        nvec++;
        if (n != 500) begin
            nerr++;
            $display("FAIL midrst_reach: got %0d writes want 500", n);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nvec++;
        if ({wr_en, clear_busy, clear_done} !== 3'b000) begin
            nerr++;
            $display("FAIL midrst_abort: got %b want 000",
                     {wr_en, clear_busy, clear_done});
        end
        repeat (5) begin
            @(negedge clk);
            nvec++;
            if ({wr_en, clear_busy, clear_done} !== 3'b000) begin
                nerr++;
                $display("FAIL midrst_quiet: got %b want 000",
                         {wr_en, clear_busy, clear_done});
            end
        end
        clear_req = 1'b1; clear_color = 6'h0A;
        @(negedge clk);
        clear_req = 1'b0;
        nvec++;
        if ({wr_en, wr_x, wr_y, wr_color, clear_busy} !==
            {1'b1, 6'd0, 5'd0, 6'h0A, 1'b1}) begin
            nerr++;
            $display("FAIL midrst_restart: got %b %0d,%0d %h busy=%b",
                     wr_en, wr_x, wr_y, wr_color, clear_busy);
        end
        for (int c = 0; c < 1300 && !seen; c++) begin
            @(negedge clk);
            nvec++;
            if (act_v !== exp_v) begin
                nerr++;
                $display("FAIL midrst_sweep c=%0d: got %h want %h",
                         c, act_v, exp_v);
            end
            if (clear_done) seen = 1'b1;
        end
        nvec++;
        if (!seen) begin
            nerr++;
            $display("FAIL midrst_done: got no clear_done want pulse");
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int nclr = 0, run = 0, maxrun = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            nvec++;
            if (act_v !== exp_v) begin
                nerr++;
                $display("FAIL random c=%0d: got %h want %h", c, act_v, exp_v);
            end
            if (pat_ack || !pat_req) run = 0;
            else if (paint_ack) run++;
            if (run > maxrun) maxrun = run;
            clear_req = 1'b0;
            if (nclr < 2 && $urandom_range(0, 299) == 0) begin
                clear_req = 1'b1;
                clear_color = 6'($urandom);
                nclr++;
            end
            if (paint_ack || !paint_req) begin
                paint_req = 1'($urandom_range(0, 1));
                paint_x = 6'($urandom_range(0, 45));
                paint_y = 5'($urandom_range(0, 33));
                paint_color = 6'($urandom);
            end
            if (pat_ack || !pat_req) begin
                pat_req = ($urandom_range(0, 3) != 0);
                pat_x = 6'($urandom_range(0, 45));
                pat_y = 5'($urandom_range(0, 33));
                pat_color = 6'($urandom);
            end
        end
        paint_req = 1'b0;
        pat_req = 1'b0;
        clear_req = 1'b0;
        nvec++;
        if (maxrun > LIMIT) begin
            nerr++;
            $display("FAIL random_starve: got run %0d want <= %0d",
                     maxrun, LIMIT);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_req = 1'b0; clear_color = '0;
        paint_req = 1'b0; paint_x = '0; paint_y = '0; paint_color = '0;
        pat_req = 1'b0; pat_x = '0; pat_y = '0; pat_color = '0;
        test_reset();
        test_single_paint();
        test_range();
        test_back_to_back();
        test_clear(1'b0);
        test_clear(1'b1);
        test_reset_mid_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
